// File: rtl/bbs_stream_decoder.sv
// bbs_stream_decoder
//   Blum-Blum-Shub stream decoder. A seed x0 is loaded, then each accepted
//   ciphertext byte is XORed with eight keystream bits. Keystream bit k is
//   the LSB of x after its (k+1)-th squaring x <= x*x mod MOD. Each squaring
//   is bit-serial (MSB first, one multiplier bit per cycle), so a byte takes
//   8*SIZE cycles from acceptance to out_valid.
//
// Optional feature: define BBS_DEC_PARITY_EN to add in_parity / parity_err
//   (even parity over in_data plus in_parity, checked at acceptance).
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   seed_load  single-cycle seed load request (IDLE / READY only)
//   seed       seed x0, accepted when 2 <= seed < MOD
//   seed_err   one-cycle pulse after a rejected seed
//   in_valid / in_ready / in_data     ciphertext byte handshake
//   out_valid / out_ready / out_data  plaintext byte handshake
//   state      generator value x, updated only at the end of each squaring
//   in_parity / parity_err            only with BBS_DEC_PARITY_EN
module bbs_stream_decoder #(
    parameter int unsigned SIZE = 16,
    parameter int unsigned MOD  = 40633
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            seed_load,
    input  logic [SIZE-1:0] seed,
    output logic            seed_err,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [7:0]      in_data,
`ifdef BBS_DEC_PARITY_EN
    input  logic            in_parity,
    output logic            parity_err,
`endif
    output logic            out_valid,
    input  logic            out_ready,
    output logic [7:0]      out_data,
    output logic [SIZE-1:0] state
);

    localparam int unsigned CNT_W = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam logic [SIZE:0] MOD_X = (SIZE+1)'(MOD);

    typedef enum logic [1:0] {IDLE, READY, SQUARE, OUTPUT} fsm_t;

    fsm_t             fsm_q, fsm_d;
    logic [SIZE-1:0]  x_q, x_d;          // generator value, constant during a squaring
    logic [SIZE-1:0]  acc_q, acc_d;      // partial product of the running squaring
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [2:0]       sq_cnt_q, sq_cnt_d;
    logic [7:0]       data_q, data_d;    // captured byte, decoded in place
    logic             seed_err_q, seed_err_d;
`ifdef BBS_DEC_PARITY_EN
    logic             parity_q, parity_d;
`endif

    logic [SIZE:0]    dbl;
    logic [SIZE:0]    sum;
    logic [SIZE-1:0]  step;
    logic             seed_ok;

    assign seed_ok   = (seed >= SIZE'(2)) && ({1'b0, seed} < MOD_X);
    assign in_ready  = (fsm_q == READY) && !seed_load;
    assign out_valid = (fsm_q == OUTPUT);
    assign out_data  = out_valid ? data_q : 8'h00;
    assign seed_err  = seed_err_q;
    assign state     = x_q;
`ifdef BBS_DEC_PARITY_EN
    assign parity_err = out_valid & parity_q;
`endif

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        fsm_d      = fsm_q;
        x_d        = x_q;
        acc_d      = acc_q;
        bit_cnt_d  = bit_cnt_q;
        sq_cnt_d   = sq_cnt_q;
        data_d     = data_q;
        seed_err_d = 1'b0;
`ifdef BBS_DEC_PARITY_EN
        parity_d   = parity_q;
`endif

        // One MSB-first interleaved modular multiply step: acc = 2*acc (+x),
        // reduced after both the shift and the add so acc stays below MOD.
        dbl = {acc_q, 1'b0};
        if (dbl >= MOD_X) dbl = dbl - MOD_X;
        sum = dbl + (x_q[bit_cnt_q] ? {1'b0, x_q} : '0);
        if (sum >= MOD_X) sum = sum - MOD_X;
        step = sum[SIZE-1:0];

        unique case (fsm_q)
            IDLE, READY: begin
                if (seed_load) begin
                    if (seed_ok) begin
                        x_d   = seed;
                        fsm_d = READY;
                    end else begin
                        seed_err_d = 1'b1;
                    end
                end else if (fsm_q == READY && in_valid) begin
                    data_d    = in_data;
                    acc_d     = '0;
                    bit_cnt_d = CNT_W'(SIZE - 1);
                    sq_cnt_d  = 3'd0;
                    fsm_d     = SQUARE;
`ifdef BBS_DEC_PARITY_EN
                    parity_d  = ^{in_data, in_parity};
`endif
                end
            end
            SQUARE: begin
                if (bit_cnt_q == '0) begin
                    // Squaring complete: publish x and fold its LSB into the byte.
                    x_d              = step;
                    acc_d            = '0;
                    bit_cnt_d        = CNT_W'(SIZE - 1);
                    data_d[sq_cnt_q] = data_q[sq_cnt_q] ^ step[0];
                    if (sq_cnt_q == 3'd7) fsm_d = OUTPUT;
                    else                  sq_cnt_d = sq_cnt_q + 3'd1;
                end else begin
                    acc_d     = step;
                    bit_cnt_d = bit_cnt_q - CNT_W'(1);
                end
            end
            OUTPUT: begin
                if (out_ready) fsm_d = READY;
            end
            default: fsm_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fsm_q      <= IDLE;
            x_q        <= '0;
            acc_q      <= '0;
            bit_cnt_q  <= '0;
            sq_cnt_q   <= '0;
            data_q     <= '0;
            seed_err_q <= 1'b0;
`ifdef BBS_DEC_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            fsm_q      <= fsm_d;
            x_q        <= x_d;
            acc_q      <= acc_d;
            bit_cnt_q  <= bit_cnt_d;
            sq_cnt_q   <= sq_cnt_d;
            data_q     <= data_d;
            seed_err_q <= seed_err_d;
`ifdef BBS_DEC_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

endmodule

// File: tb/tb_bbs_stream_decoder.sv
// tb_bbs_stream_decoder
//   Directed bench for bbs_stream_decoder. Expected bytes and generator
//   values come from a reference model using plain modular arithmetic and
//   are queued when a byte is driven, then popped when out_valid appears.
module tb_bbs_stream_decoder;

    localparam int unsigned SIZE = 16;
    localparam int unsigned MOD  = 40633;

    logic            clk = 1'b0;
    logic            reset;
    logic            seed_load;
    logic [SIZE-1:0] seed;
    logic            seed_err;
    logic            in_valid;
    logic            in_ready;
    logic [7:0]      in_data;
    logic            in_parity;
    logic            out_valid;
    logic            out_ready;
    logic [7:0]      out_data;
    logic [SIZE-1:0] state;
`ifdef BBS_DEC_PARITY_EN
    logic            parity_err;
`endif

    typedef struct {
        logic [7:0]      data;
        logic [SIZE-1:0] x;
        logic            par;
    } exp_t;

    exp_t        exp_q[$];
    longint      model_x;
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    bbs_stream_decoder #(.SIZE(SIZE), .MOD(MOD)) dut (
        .clk        (clk),
        .reset      (reset),
        .seed_load  (seed_load),
        .seed       (seed),
        .seed_err   (seed_err),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
`ifdef BBS_DEC_PARITY_EN
        .in_parity  (in_parity),
        .parity_err (parity_err),
`endif
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .state      (state)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: eight squarings, keystream bit k = LSB after squaring k+1.
    task automatic model_push(input logic [7:0] d, input logic par);
        exp_t   e;
        longint x;
        x = model_x;
        e.data = d;
        for (int k = 0; k < 8; k++) begin
            x = (x * x) % MOD;
            e.data[k] = d[k] ^ x[0];
        end
        model_x = x;
        e.x     = x[SIZE-1:0];
        e.par   = ^{d, par};
        exp_q.push_back(e);
    endtask

    task automatic load_seed(input logic [SIZE-1:0] s);
        @(negedge clk);
        seed_load = 1'b1;
        seed      = s;
        @(negedge clk);
        seed_load = 1'b0;
    endtask

    // Drive one byte, wait for out_valid, compare against the scoreboard,
    // optionally stall the sink and/or poke seed_load mid-squaring.
    task automatic run_byte(input string tag, input logic [7:0] d, input logic par,
                            input int hold, input logic poke);
        exp_t e;
        int   cnt;
        int   unstable;
        @(negedge clk);
        in_valid  = 1'b1;
        in_data   = d;
        in_parity = par;
        model_push(d, par);
        @(posedge clk); #1;
        check({tag, "_busy"}, {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        cnt = 0;
        while (!out_valid && cnt < 400) begin
            @(posedge clk); #1;
            cnt++;
            if (poke && cnt == 10) begin
                @(negedge clk);
                seed_load = 1'b1;
                seed      = SIZE'(500);
            end
            if (poke && cnt == 11) begin
                check({tag, "_poke_err"}, {31'd0, seed_err}, 32'd0);
                @(negedge clk);
                seed_load = 1'b0;
            end
        end
        check({tag, "_latency"}, cnt, 32'(8 * SIZE));
        e = exp_q.pop_front();
        unstable = 0;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (!out_valid || out_data !== e.data || in_ready) unstable++;
        end
        if (hold > 0) check({tag, "_stall"}, unstable, 32'd0);
        check({tag, "_data"}, {24'd0, out_data}, {24'd0, e.data});
        check({tag, "_state"}, {16'd0, state}, {16'd0, e.x});
`ifdef BBS_DEC_PARITY_EN
        check({tag, "_parity"}, {31'd0, parity_err}, {31'd0, e.par});
`endif
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        check({tag, "_release"}, {30'd0, out_valid, in_ready}, 32'd1);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        int seen;
        logic [SIZE-1:0] bad_seeds [3];
        bad_seeds[0] = SIZE'(0);
        bad_seeds[1] = SIZE'(1);
        bad_seeds[2] = SIZE'(MOD);
        reset     = 1'b1;
        seed_load = 1'b0;
        seed      = '0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_parity = 1'b0;
        out_ready = 1'b0;
        model_x   = 0;

        // Asynchronous reset, sampled without a clock edge.
        #3 reset = 1'b0;
        #1;
        check("rst_outputs", {seed_err, in_ready, out_valid, out_data, state},
              {1'b0, 1'b0, 1'b0, 8'h00, 16'h0000});
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Rejected seeds: error pulse, still unseeded.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            seed_load = 1'b1;
            seed      = bad_seeds[i];
            @(posedge clk); #1;
            check("bad_seed_err", {31'd0, seed_err}, 32'd1);
            @(negedge clk);
            seed_load = 1'b0;
            @(posedge clk); #1;
            check("bad_seed_pulse", {31'd0, seed_err}, 32'd0);
            check("bad_seed_idle", {15'd0, in_ready, state}, 32'd0);
        end

        // Valid seed.
        load_seed(SIZE'(200));
        model_x = 200;
        #1;
        check("seed_state", {16'd0, state}, 32'd200);
        check("seed_ready", {31'd0, in_ready}, 32'd1);

        // Known vector, then continue without re-seed.
        run_byte("b00", 8'h00, 1'b0, 0, 1'b0);
        check("b00_known", {16'd0, state}, 32'd6421);
        run_byte("b5a", 8'h5A, 1'b0, 0, 1'b0);

        // Re-seed, decode 0xA0 with a 20-cycle sink stall.
        load_seed(SIZE'(200));
        model_x = 200;
        run_byte("ba0", 8'hA0, 1'b0, 20, 1'b0);

        // seed_load and in_valid in the same cycle: seed wins.
        @(negedge clk);
        seed_load = 1'b1;
        seed      = SIZE'(300);
        in_valid  = 1'b1;
        in_data   = 8'h3C;
        #1;
        check("collide_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        model_x = 300;
        @(negedge clk);
        seed_load = 1'b0;
        in_valid  = 1'b0;
        #1;
        check("collide_state", {16'd0, state}, 32'd300);
        check("collide_ready2", {31'd0, in_ready}, 32'd1);

        // seed_load during SQUARE is ignored.
        run_byte("poke", 8'hC3, 1'b0, 0, 1'b1);

        // Reset 60 cycles into a byte: aborted, no output, re-seed needed.
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'h11;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (59) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("abort_outputs", {in_ready, out_valid, out_data, state}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        seen = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (out_valid || in_ready) seen++;
        end
        check("abort_silent", seen, 32'd0);

`ifdef BBS_DEC_PARITY_EN
        load_seed(SIZE'(200));
        model_x = 200;
        run_byte("par_bad", 8'h01, 1'b0, 0, 1'b0);
        run_byte("par_ok", 8'h01, 1'b1, 0, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bbs_stream_decoder.md
BBS_STREAM_DECODER -- requirements
Module: bbs_stream_decoder

Interface
REQ-001 SHALL have parameter SIZE, default 16, modulus/state width in bits.
REQ-002 SHALL have parameter MOD, default 40633 (179*227, Blum integer), BBS modulus, MOD < 2^SIZE.
REQ-003 SHALL have port clk, input, 1, sole clock, rising-edge.
REQ-004 SHALL have port reset, input, 1; one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port seed_load, input, 1, single-cycle request to load seed.
REQ-006 SHALL have port seed, input, SIZE, BBS seed x0.
REQ-007 SHALL have port seed_err, output, 1, one-cycle pulse on rejected seed.
REQ-008 SHALL have port in_valid, input, 1, ciphertext byte valid.
REQ-009 SHALL have port in_ready, output, 1, decoder accepts ciphertext byte.
REQ-010 SHALL have port in_data, input, 8, ciphertext byte.
REQ-011 SHALL have port out_valid, output, 1, plaintext byte valid.
REQ-012 SHALL have port out_ready, input, 1, sink accepts plaintext.
REQ-013 SHALL have port out_data, output, 8, plaintext byte.
REQ-014 SHALL have port state, output, SIZE, current generator value x.

Function
REQ-015 SHALL implement FSM states IDLE (unseeded), READY, SQUARE, OUTPUT.
REQ-016 SHALL, on seed_load in IDLE or READY, accept seed if 2 <= seed < MOD: state <= seed, go READY; else pulse seed_err next cycle, state and FSM unchanged.
REQ-017 SHALL ignore seed_load in SQUARE and OUTPUT (no seed_err).
REQ-018 SHALL drive in_ready = 1 only in READY with seed_load low (seed_load wins on same cycle, byte not accepted).
REQ-019 SHALL, on in_valid & in_ready, capture in_data and enter SQUARE.
REQ-020 SHALL perform 8 successive squarings x <= x*x mod MOD, each bit-serial MSB-first over exactly SIZE cycles using SIZE+1-bit intermediate with conditional subtract of MOD after every shift and add.
REQ-021 SHALL take keystream bit k (k=0..7) as LSB of x after squaring k+1; out_data[k] = captured in_data[k] XOR keystream bit k.
REQ-022 SHALL assert out_valid exactly 8*SIZE cycles (128 default) after the accepting edge and hold out_data/out_valid stable until out_ready.
REQ-023 SHALL, on out_valid & out_ready, return to READY; next byte continues from updated x (no re-seed).
REQ-024 SHALL update state output only at end of each full squaring (never mid-iteration values).

Reset
REQ-025 SHALL, on reset low, asynchronously clear: FSM to IDLE, state=0, in_ready=0, out_valid=0, out_data=0, seed_err=0, all counters 0.
REQ-026 SHALL abort any in-flight byte on reset; no output produced; re-seed required.

Configuration
REQ-027 SHALL, with macro BBS_DEC_PARITY_EN defined, add input in_parity (1) and output parity_err (1): even parity over in_data plus in_parity checked at acceptance; parity_err valid with out_valid, byte still decoded.
REQ-028 SHALL, without BBS_DEC_PARITY_EN, omit in_parity and parity_err entirely; behaviour otherwise identical.

Verification
REQ-029 SHALL cover: reset low -> all outputs 0, in_ready=0; seed_load with seed=200 -> READY, state=200, in_ready=1.
REQ-030 SHALL cover: seed=200, in_data=0x00 accepted -> out_valid 128 cycles later, out_data=0xA0, state=6421.
REQ-031 SHALL cover: seed=200, in_data=0xA0 -> out_data=0x00; out_ready held low 20 cycles -> out_data stable, in_ready=0.
REQ-032 SHALL cover: seed=0, seed=1, seed=40633 each -> seed_err pulse, FSM stays IDLE, state=0.
REQ-033 SHALL cover: seed_load and in_valid same cycle in READY -> seed loaded, byte not accepted; seed_load during SQUARE -> ignored, result unaffected.
REQ-034 SHALL cover: reset low at cycle 60 of SQUARE -> immediate IDLE, out_valid never asserted; with BBS_DEC_PARITY_EN, in_data=0x01, in_parity=0 -> parity_err=1.
